// File: rtl/adder_sat_stage_if.sv
// Handshake and data bundle between the adder, the saturating output stage and its consumer.
// The stage itself uses the slave view; whoever drives the adder side and consumes results uses master.
interface adder_sat_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             overFlow;
    logic             A_msb;
    logic             sat_en;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             res_cout;
    logic             res_ovf;

    modport master (
        output in_valid, S, Cout, overFlow, A_msb, sat_en, out_ready,
        input  in_ready, out_valid, result, res_cout, res_ovf
    );

    modport slave (
        input  in_valid, S, Cout, overFlow, A_msb, sat_en, out_ready,
        output in_ready, out_valid, result, res_cout, res_ovf
    );
endinterface

// File: rtl/adder_sat_stage.sv
// Output stage behind rippleCarryAdder32: optional signed saturation, 2-deep result FIFO,
// and sticky/counting overflow status.
module adder_sat_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    adder_sat_stage_if.slave   bus,
    input  logic               clr_sticky,
    output logic               sticky_ovf,
    output logic [CNT_W-1:0]   ovf_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } fifo_state_t;

    localparam logic [WIDTH-1:0] MAX_INT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    fifo_state_t state;
    fifo_state_t next_state;

    logic             push;
    logic             pop;
    logic             load_head_new;
    logic             load_head_tail;
    logic             load_tail;
    logic [WIDTH-1:0] cap_result;

    logic [WIDTH-1:0] head_result;
    logic             head_cout;
    logic             head_ovf;
    logic [WIDTH-1:0] tail_result;
    logic             tail_cout;
    logic             tail_ovf;

    // Handshake flags depend on the state alone, so a FULL stage refuses input even while popping.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        cap_result = bus.S;
        if (bus.sat_en && bus.overFlow) begin
            cap_result = bus.A_msb ? MIN_INT : MAX_INT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state    = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    next_state = FULL;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state     = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // The head register drives the outputs directly, so they only change on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_result <= '0;
            head_cout   <= 1'b0;
            head_ovf    <= 1'b0;
            tail_result <= '0;
            tail_cout   <= 1'b0;
            tail_ovf    <= 1'b0;
        end else begin
            if (load_head_new) begin
                head_result <= cap_result;
                head_cout   <= bus.Cout;
                head_ovf    <= bus.overFlow;
            end else if (load_head_tail) begin
                head_result <= tail_result;
                head_cout   <= tail_cout;
                head_ovf    <= tail_ovf;
            end
            if (load_tail) begin
                tail_result <= cap_result;
                tail_cout   <= bus.Cout;
                tail_ovf    <= bus.overFlow;
            end
        end
    end

    assign bus.result   = head_result;
    assign bus.res_cout = head_cout;
    assign bus.res_ovf  = head_ovf;

    // An overflow push outranks a simultaneous clear, leaving a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (push && bus.overFlow) begin
            sticky_ovf <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule
